// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   arb_state_e : sequencer state encoding (3 bits)
//   NOP_INSTR   : instruction shown to the decoder while no fetch has landed
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    DATA   = 3'd3,
    COMMIT = 3'd4,
    ERROR  = 3'd5
  } arb_state_e;

  // addi x0, x0, 0 -- decodes as no load and no store
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Request watchdog: counts consecutive cycles with an outstanding request
// and no acknowledge.
//   clk, reset : clock, async active-low reset
//   en         : request pending this cycle and not acknowledged
//   clr        : restart the count (ack seen or no request)
//   expired    : this is the TIMEOUT-th unacknowledged cycle; never set when
//                TIMEOUT==0
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Count value seen during the last allowed wait cycle
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clr)    count <= '0;
    else if (en)     count <= count + 1'b1;
  end

  // Flag during the cycle whose closing edge would make the count hit TIMEOUT,
  // so the sequencer leaves on exactly that edge.
  assign expired = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the core's
// instruction fetch and its load/store access. Each instruction is sequenced
// fetch -> decode -> optional data access -> one commit cycle.
//   clk, reset          : clock, async active-low reset
//   core_instr_addr     : PC (stable while stall=1)
//   core_instr          : registered fetched instruction for the decoder
//   core_data_addr      : load/store address
//   core_should_read/
//   core_should_write   : decoded memory access (write wins if both)
//   core_write_data     : store data
//   core_hold           : core cannot commit this cycle
//   core_read_data      : registered load data
//   stall               : core must not update PC/registers/memory
//   mem_req/we/addr/
//   wdata/ack/rdata     : memory req/ack handshake
//   bus_error           : sticky watchdog error (cleared only by reset)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_instr_addr,
  output logic [DATA_W-1:0] core_instr,
  input  logic [ADDR_W-1:0] core_data_addr,
  input  logic              core_should_read,
  input  logic              core_should_write,
  input  logic [DATA_W-1:0] core_write_data,
  input  logic              core_hold,
  output logic [DATA_W-1:0] core_read_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_error
);

  arb_state_e state;
  logic       in_fetch, in_data;
  logic       mem_access;
  logic       wd_en, wd_expired;

  assign in_fetch   = (state == FETCH);
  assign in_data    = (state == DATA);
  assign mem_access = core_should_read | core_should_write;

  // Request side is a pure decode of the state register, so an async reset
  // drops mem_req immediately; core inputs are stable while stalled, which
  // keeps addr/we/wdata steady until the ack.
  assign mem_req   = in_fetch | in_data;
  assign mem_we    = in_data & core_should_write;
  assign mem_addr  = in_fetch ? core_instr_addr :
                     in_data  ? core_data_addr  : '0;
  assign mem_wdata = in_data ? core_write_data : '0;
  assign bus_error = (state == ERROR);

  // Only two places let the core advance: a non-memory instruction in decode,
  // or the commit slot after its data access. Both gated by core_hold.
  always_comb begin
    stall = 1'b1;
    case (state)
      DECODE:  if (!core_hold && !mem_access) stall = 1'b0;
      COMMIT:  if (!core_hold)                stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  assign wd_en = mem_req & ~mem_ack;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .en      (wd_en),
    .clr     (~wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      core_instr     <= DATA_W'(NOP_INSTR);
      core_read_data <= '0;
    end else begin
      case (state)
        IDLE:   state <= FETCH;
        FETCH: begin
          if (mem_ack) begin
            core_instr <= mem_rdata;
            state      <= DECODE;
          end else if (wd_expired) begin
            state <= ERROR;
          end
        end
        DECODE: begin
          if (!core_hold) state <= mem_access ? DATA : FETCH;
        end
        DATA: begin
          if (mem_ack) begin
            if (core_should_read && !core_should_write) core_read_data <= mem_rdata;
            state <= COMMIT;
          end else if (wd_expired) begin
            state <= ERROR;
          end
        end
        COMMIT: if (!core_hold) state <= FETCH;
        ERROR:  state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. Stimulus is described per
// instruction (fetch waits, decode hold, access kind, data waits, commit
// hold); from that description the bench lays out the cycle-by-cycle inputs
// and expected outputs, then replays and compares them every cycle.
module tb_mem_port_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] core_instr_addr, core_instr, core_data_addr, core_write_data;
  logic [31:0] core_read_data, mem_addr, mem_wdata, mem_rdata;
  logic        core_should_read, core_should_write, core_hold;
  logic        stall, mem_req, mem_we, mem_ack, bus_error;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .core_instr_addr   (core_instr_addr),
    .core_instr        (core_instr),
    .core_data_addr    (core_data_addr),
    .core_should_read  (core_should_read),
    .core_should_write (core_should_write),
    .core_write_data   (core_write_data),
    .core_hold         (core_hold),
    .core_read_data    (core_read_data),
    .stall             (stall),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .bus_error         (bus_error)
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] pc, daddr, wdata, rdata;
    logic        rd, wr, hold, ack;
    logic        e_req, e_we, e_stall, e_err;
    logic [31:0] e_addr, e_wdata, e_instr, e_rdat;
    int          gap;   // literal distance to previous commit (0 = unchecked)
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] m_instr, m_rdata;
  int          n_stores = 0;
  int          checks = 0, failures = 0;
  int          cyc_idx = 0;

  // A cycle where nothing the arbiter should look at is meaningful: all
  // core/memory inputs random, outputs idle with stall high.
  function automatic cyc_t blank(input logic [31:0] pc);
    cyc_t c;
    c.rst_n = 1'b1;  c.pc = pc;
    c.daddr = $urandom; c.wdata = $urandom; c.rdata = $urandom;
    c.rd = 1'($urandom_range(0, 1)); c.wr = 1'($urandom_range(0, 1));
    c.hold = 1'($urandom_range(0, 1)); c.ack = 1'($urandom_range(0, 1));
    c.e_req = 1'b0; c.e_we = 1'b0; c.e_stall = 1'b1; c.e_err = 1'b0;
    c.e_addr = '0; c.e_wdata = '0; c.e_instr = m_instr; c.e_rdat = m_rdata;
    c.gap = 0;
    return c;
  endfunction

  task automatic add_reset(input logic [31:0] pc);
    cyc_t c;
    m_instr = NOP; m_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      c = blank(pc); c.rst_n = 1'b0; q.push_back(c);
    end
    c = blank(pc); q.push_back(c);  // one IDLE cycle after release
  endtask

  task automatic add_fetch(input logic [31:0] pc, input logic [31:0] instr, input int wf);
    cyc_t c;
    for (int i = 0; i <= wf; i++) begin
      c = blank(pc);
      c.ack = (i == wf);
      if (i == wf) c.rdata = instr;
      c.e_req = 1'b1; c.e_addr = pc;
      q.push_back(c);
    end
    m_instr = instr;
  endtask

  function automatic cyc_t core_cyc(input logic [31:0] pc, input logic [1:0] op,
                                    input logic [31:0] da, input logic [31:0] wd,
                                    input logic hold);
    cyc_t c;
    c = blank(pc);
    c.rd = op[0]; c.wr = op[1]; c.daddr = da; c.wdata = wd; c.hold = hold;
    return c;
  endfunction

  // op: 0 none, 1 load, 2 store, 3 load+store (store wins)
  task automatic add_instr(input logic [31:0] pc, input logic [31:0] instr, input int wf,
                           input int hd, input logic [1:0] op, input logic [31:0] da,
                           input logic [31:0] wd, input logic [31:0] rdv, input int wdw,
                           input int hc, input int gap);
    cyc_t c;
    add_fetch(pc, instr, wf);
    for (int i = 0; i < hd; i++) q.push_back(core_cyc(pc, op, da, wd, 1'b1));
    c = core_cyc(pc, op, da, wd, 1'b0);
    if (op == 2'd0) begin
      c.e_stall = 1'b0; c.gap = gap; q.push_back(c);
      return;
    end
    q.push_back(c);
    for (int i = 0; i <= wdw; i++) begin
      c = core_cyc(pc, op, da, wd, 1'($urandom_range(0, 1)));
      c.ack = (i == wdw);
      if (i == wdw) c.rdata = rdv;
      c.e_req = 1'b1; c.e_we = op[1]; c.e_addr = da; c.e_wdata = wd;
      q.push_back(c);
    end
    if (op[1]) n_stores++;
    if (op == 2'd1) m_rdata = rdv;
    for (int i = 0; i < hc; i++) q.push_back(core_cyc(pc, op, da, wd, 1'b1));
    c = core_cyc(pc, op, da, wd, 1'b0);
    c.e_stall = 1'b0; c.gap = gap;
    q.push_back(c);
  endtask

  // Load whose data access is cut short by reset after two wait cycles
  task automatic add_abort(input logic [31:0] pc, input logic [31:0] da);
    cyc_t c;
    add_fetch(pc, 32'h0000_2083, 0);
    q.push_back(core_cyc(pc, 2'd1, da, 32'h0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      c = core_cyc(pc, 2'd1, da, 32'h0, 1'b0);
      c.ack = 1'b0; c.e_req = 1'b1; c.e_addr = da; c.e_wdata = 32'h0;
      q.push_back(c);
    end
    add_reset(pc);
  endtask

  // Fetch that never acks: 4 request cycles, then stuck in error
  task automatic add_timeout(input logic [31:0] pc);
    cyc_t c;
    for (int i = 0; i < 4; i++) begin
      c = blank(pc); c.ack = 1'b0; c.e_req = 1'b1; c.e_addr = pc; q.push_back(c);
    end
    for (int i = 0; i < 3; i++) begin
      c = blank(pc); c.e_err = 1'b1; q.push_back(c);
    end
    add_reset(pc);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc_idx, act, exp);
    end
  endtask

  initial begin
    cyc_t c;
    int   last_commit = -1;
    int   dut_writes  = 0;
    logic [1:0] op;

    reset = 1'b0;
    core_instr_addr = '0; core_data_addr = '0; core_write_data = '0;
    core_should_read = 1'b0; core_should_write = 1'b0; core_hold = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;

    // ---- build the scenario ----
    add_reset(32'h0);
    add_instr(32'h0, NOP, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    add_instr(32'h4, NOP, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2);
    add_instr(32'h8, NOP, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2);
    add_instr(32'hC,  32'h1000_2083, 0, 0, 2'd1, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, 0, 6);
    add_instr(32'h10, 32'h2020_2023, 0, 0, 2'd2, 32'h200, 32'h1234_5678, 32'h0, 2, 0, 6);
    add_instr(32'h14, 32'h0040_2103, 0, 5, 2'd1, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 5, 14);
    add_instr(32'h18, NOP, 0, 5, 2'd0, 0, 0, 0, 0, 0, 7);
    add_instr(32'h1C, 32'h0050_2223, 1, 0, 2'd3, 32'h400, 32'hA5A5_5A5A, 32'h7777_7777, 1, 0, 0);
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      add_instr($urandom & 32'hFFFF_FFFC, $urandom, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, op,
                $urandom, $urandom, $urandom, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, 0);
    end
    add_abort(32'h40, 32'h500);
    add_instr(32'h40, NOP, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    add_timeout(32'h44);
    add_instr(32'h44, 32'h0000_3083, 0, 0, 2'd1, 32'h600, 0, 32'h0BAD_F00D, 0, 0, 0);

    // ---- replay and compare ----
    for (int i = 0; i < q.size(); i++) begin
      c = q[i];
      @(negedge clk);
      cyc_idx = i;
      reset = c.rst_n;
      core_instr_addr = c.pc; core_data_addr = c.daddr; core_write_data = c.wdata;
      core_should_read = c.rd; core_should_write = c.wr; core_hold = c.hold;
      mem_ack = c.ack; mem_rdata = c.rdata;
      #1;
      chk("mem_req",        32'(mem_req),   32'(c.e_req));
      chk("mem_we",         32'(mem_we),    32'(c.e_we));
      chk("mem_addr",       mem_addr,       c.e_addr);
      chk("mem_wdata",      mem_wdata,      c.e_wdata);
      chk("stall",          32'(stall),     32'(c.e_stall));
      chk("bus_error",      32'(bus_error), 32'(c.e_err));
      chk("core_instr",     core_instr,     c.e_instr);
      chk("core_read_data", core_read_data, c.e_rdat);
      if (reset && mem_req && mem_we && mem_ack) dut_writes++;
      if (!stall) begin
        if (c.gap != 0) chk("commit_gap", 32'(i - last_commit), 32'(c.gap));
        last_commit = i;
      end
    end
    chk("store_count", 32'(dut_writes), 32'(n_stores));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the core's instruction fetch and its load/store data access.
- Sequences each instruction in order: fetch, present the instruction to the core's decoder, optionally perform one data access, then release the core for exactly one commit cycle.
- Sits between the Riscv core ports (instr_addr, instr, data_addr, should_read_mem, should_write_mem, mem_write_data, mem_read_data) and a variable-latency memory with a req/ack handshake.
- Its stall output ORs into the core's no_update.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- TIMEOUT, 255, cycles without mem_ack before declaring a bus error; 0 disables the watchdog

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (reset==0 resets)
- core_instr_addr  in  ADDR_W  core PC; stable while stall=1
- core_instr  out  DATA_W  registered fetched instruction, fed to the core's decoder
- core_data_addr  in  ADDR_W  core ALU result used as data address
- core_should_read  in  1  core decode: load
- core_should_write  in  1  core decode: store
- core_write_data  in  DATA_W  store data
- core_hold  in  1  core cannot commit this cycle (FPU busy)
- core_read_data  out  DATA_W  registered load data
- stall  out  1  1 = core must not update PC/registers/memory
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  request completed this cycle; mem_rdata valid
- mem_rdata  in  DATA_W  read data
- bus_error  out  1  sticky watchdog error

Behaviour:
- Reset values, applied immediately on reset==0:
  - state=IDLE; core_instr=32'h00000013 (NOP, so decode shows no memory access)
  - core_read_data=0; stall=1; mem_req=0; bus_error=0; watchdog count=0
- FSM states: IDLE, FETCH, DECODE, DATA, COMMIT, ERROR.
- IDLE: stall=1; go to FETCH next cycle.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=core_instr_addr.
  - On posedge with mem_ack=1: core_instr<=mem_rdata, then DECODE.
- DECODE:
  - mem_req=0, giving a mandatory one-cycle gap between transactions.
  - If core_hold=1: stay in DECODE with stall=1.
  - Else if core_should_read or core_should_write: go to DATA, stall=1.
  - Else: stall=0 this cycle (core commits), then FETCH.
- DATA:
  - mem_req=1, mem_addr=core_data_addr, mem_we=core_should_write, mem_wdata=core_write_data.
  - If both read and write are asserted, write wins.
  - On ack: for a read, core_read_data<=mem_rdata; go to COMMIT.
- COMMIT:
  - mem_req=0.
  - If core_hold=1: stay, stall=1, core_instr/core_read_data held.
  - Else stall=0 for exactly this cycle, then FETCH.
- mem_addr, mem_we, mem_wdata:
  - Combinational from state and core inputs.
  - Driven 0 whenever mem_req=0.
  - Held stable while mem_req=1 until ack is sampled.
- Zero-wait ack (ack in the first req cycle) is legal. mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory:
  - Non-memory instruction: 2 cycles (FETCH, DECODE).
  - Load/store: 4 cycles (FETCH, DECODE, DATA, COMMIT).
  - Each memory wait state adds 1 cycle.
- Watchdog (FETCH and DATA only):
  - Counts consecutive req cycles without ack; clears on ack or state exit.
  - When the count reaches TIMEOUT (TIMEOUT>0): go to ERROR.
- ERROR: mem_req=0, stall=1, bus_error=1. Exit only via reset.
- Reset mid-transaction: mem_req drops asynchronously. The memory must tolerate an abandoned request; a late ack is ignored. After release, fetch restarts at core_instr_addr.
- stall is 0 only in DECODE (no memory access, no hold) or COMMIT (no hold). This guarantees one store per committed instruction and no double commit.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants (3-bit): IDLE=0, FETCH=1, DECODE=2, DATA=3, COMMIT=4, ERROR=5
  - NOP_INSTR=32'h00000013
- One natural sub-module, mem_arb_watchdog: TIMEOUT counter with count-enable, clear, and an expired output.

Test Plan:
- Zero-wait memory (mem_ack=1), instructions all NOP, PC stepping 0,4,8 -> mem_addr alternates between PC and 0; stall low every 2nd cycle; mem_req never asserted in DECODE.
- Load, core_data_addr=0x100, 2 wait states, mem_rdata=0xDEADBEEF -> core_read_data=0xDEADBEEF in COMMIT; stall low exactly 1 cycle; 6 cycles total per instruction.
- Store, addr=0x200, data=0x12345678, ack after 3 cycles -> mem_we=1; addr/wdata stable for all 3 req cycles; exactly one write transaction per instruction.
- core_hold=1 for 5 cycles in DECODE and in COMMIT -> stall stays 1; no mem_req; core_instr/core_read_data unchanged; proceeds on the first cycle with hold=0.
- TIMEOUT=4, mem_ack never asserted -> bus_error=1 after 4 req cycles; mem_req=0; stall=1 until reset.
- reset=0 asserted mid-DATA wait -> mem_req=0 immediately (before the next clk edge) and all outputs at reset values; after release, a FETCH to the current PC is the first request.
